// File: rtl/genius_sequencer_pkg.sv
// ============================================================================
// genius_sequencer_pkg
// State codes and LFSR step shared by the Genius/Simon sequencer blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package genius_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADD      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_WIN      = 3'd5,
        ST_LOSE     = 3'd6
    } state_t;

    localparam int          LFSR_W    = 16;
    // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/genius_lfsr.sv
// ============================================================================
// genius_lfsr
// Free-running 16-bit Galois LFSR; advances every cycle out of reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module genius_lfsr
    import genius_sequencer_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

`default_nettype wire

// File: rtl/genius_sequencer.sv
// ============================================================================
// genius_sequencer
// Genius/Simon game core: grows a random sequence, plays it back, checks input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module genius_sequencer
    import genius_sequencer_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          MAX_LEN     = 32,
    parameter int          ON_CYC      = 25000000,
    parameter int          OFF_CYC     = 12500000,
    parameter int          TIMEOUT_CYC = 250000000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                         CLOCK_50,
    input  logic                         RESET_N,
    input  logic                         i_start,
    input  logic [N_CH-1:0]              i_btn,
    output logic [N_CH-1:0]              o_led,
    output logic [$clog2(MAX_LEN+1)-1:0] o_level,
    output logic [2:0]                   o_state,
    output logic                         o_win,
    output logic                         o_lose
);

    localparam int CW   = $clog2(N_CH);
    localparam int LW   = $clog2(MAX_LEN+1);
    localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int MAXA = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int MAXC = (MAXA > TIMEOUT_CYC) ? MAXA : TIMEOUT_CYC;
    localparam int TW   = $clog2(MAXC) + 1;

    localparam logic [TW-1:0] c_on_last  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] c_off_last = TW'(OFF_CYC - 1);
    localparam logic [TW-1:0] c_to_last  = TW'(TIMEOUT_CYC - 1);
    localparam logic [LW-1:0] c_len_max  = LW'(MAX_LEN);

    state_t          r_state, w_state_nx;
    logic [LW-1:0]   r_level, w_level_nx;
    logic [LW-1:0]   r_idx,   w_idx_nx;
    logic [TW-1:0]   r_timer, w_timer_nx, w_timer_inc;
    logic [N_CH-1:0] r_led,   w_led_nx;
    logic [CW-1:0]   r_mem [0:MAX_LEN-1];
    logic            w_mem_we;
    logic [15:0]     w_lfsr;
    logic [CW-1:0]   w_show_sym;
    logic [N_CH-1:0] w_exp_oh;
    logic            w_last, w_press, w_btn_onehot;

    function automatic logic [N_CH-1:0] f_onehot(input logic [CW-1:0] s);
        f_onehot    = '0;
        f_onehot[s] = 1'b1;
    endfunction

    genius_lfsr #(.SEED(SEED)) u_lfsr (
        .clk    (CLOCK_50),
        .rst_n  (RESET_N),
        .o_lfsr (w_lfsr)
    );

    assign w_last       = (r_idx == (r_level - LW'(1)));
    assign w_exp_oh     = f_onehot(r_mem[r_idx[AW-1:0]]);
    assign w_press      = |i_btn;
    assign w_btn_onehot = w_press && ((i_btn & (i_btn - N_CH'(1))) == '0);
    assign w_timer_inc  = (r_timer == '1) ? r_timer : r_timer + TW'(1);

    always_comb begin
        w_state_nx = r_state;
        w_level_nx = r_level;
        w_idx_nx   = r_idx;
        w_timer_nx = w_timer_inc;
        w_mem_we   = 1'b0;
        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (i_start) begin
                    w_state_nx = ST_ADD;
                    w_level_nx = '0;
                end
            end
            ST_ADD: begin
                w_mem_we   = 1'b1;
                w_level_nx = r_level + LW'(1);
                w_idx_nx   = '0;
                w_timer_nx = '0;
                w_state_nx = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (r_timer == c_on_last) begin
                    w_timer_nx = '0;
                    w_state_nx = ST_SHOW_OFF;
                end
            end
            ST_SHOW_OFF: begin
                if (r_timer == c_off_last) begin
                    w_timer_nx = '0;
                    if (w_last) begin
                        w_idx_nx   = '0;
                        w_state_nx = ST_WAIT_IN;
                    end else begin
                        w_idx_nx   = r_idx + LW'(1);
                        w_state_nx = ST_SHOW_ON;
                    end
                end
            end
            ST_WAIT_IN: begin
                // A press on the timeout cycle takes priority over the timeout
                if (w_press) begin
                    if (!w_btn_onehot || (i_btn != w_exp_oh)) begin
                        w_state_nx = ST_LOSE;
                    end else if (!w_last) begin
                        w_idx_nx   = r_idx + LW'(1);
                        w_timer_nx = '0;
                    end else if (r_level == c_len_max) begin
                        w_state_nx = ST_WIN;
                    end else begin
                        w_state_nx = ST_ADD;
                    end
                end else if (r_timer == c_to_last) begin
                    w_state_nx = ST_LOSE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // The first playback step of a new game reads the symbol being written this cycle
    assign w_show_sym = ((r_state == ST_ADD) && (r_level == '0)) ? w_lfsr[CW-1:0]
                                                                 : r_mem[w_idx_nx[AW-1:0]];

    always_comb begin
        w_led_nx = '0;
        case (w_state_nx)
            ST_SHOW_ON: w_led_nx = f_onehot(w_show_sym);
            ST_WAIT_IN: w_led_nx = (r_state == ST_WAIT_IN) ? i_btn : '0;
            ST_WIN:     w_led_nx = '1;
            default:    w_led_nx = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_level <= '0;
            r_idx   <= '0;
            r_timer <= '0;
            r_led   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_level <= w_level_nx;
            r_idx   <= w_idx_nx;
            r_timer <= w_timer_nx;
            r_led   <= w_led_nx;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (w_mem_we) begin
            r_mem[r_level[AW-1:0]] <= w_lfsr[CW-1:0];
        end
    end

    assign o_led   = r_led;
    assign o_level = r_level;
    assign o_state = r_state;
    assign o_win   = (r_state == ST_WIN);
    assign o_lose  = (r_state == ST_LOSE);

endmodule

`default_nettype wire

// File: tb/tb_genius_sequencer.sv
// ============================================================================
// tb_genius_sequencer
// Randomised self-checking bench for genius_sequencer with short timing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_genius_sequencer;

    localparam int N_CH        = 4;
    localparam int MAX_LEN     = 3;
    localparam int ON_CYC      = 4;
    localparam int OFF_CYC     = 2;
    localparam int TIMEOUT_CYC = 20;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic [3:0] btn     = 4'd0;
    logic [3:0] o_led;
    logic [1:0] o_level;
    logic [2:0] o_state;
    logic       o_win;
    logic       o_lose;

    int n_vec = 0;
    int n_err = 0;
    int seq[$];
    logic [15:0] m_lfsr;

    genius_sequencer #(
        .N_CH        (N_CH),
        .MAX_LEN     (MAX_LEN),
        .ON_CYC      (ON_CYC),
        .OFF_CYC     (OFF_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SEED        (16'hACE1)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .i_start  (start),
        .i_btn    (btn),
        .o_led    (o_led),
        .o_level  (o_level),
        .o_state  (o_state),
        .o_win    (o_win),
        .o_lose   (o_lose)
    );

    always #5 clk = ~clk;

    // Reference random source: the specified Galois LFSR, stepped every cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Called at the negedge of an ADD cycle; checks the full playback that follows.
    task automatic observe_round(input int exp_level, input bit noise);
        int on, off;
        bit ok;
        check("add_state", o_state, 1);
        seq.push_back(int'(m_lfsr[1:0]));
        tick();
        check("level", o_level, exp_level);
        for (int i = 0; i < seq.size(); i++) begin
            on = 0; off = 0; ok = 1'b1;
            while (o_state == 3'd2 && on < 100) begin
                if (o_led !== 4'(1 << seq[i])) ok = 1'b0;
                on++;
                if (noise) begin
                    btn   = 4'(1 << $urandom_range(0, 3));
                    start = 1'($urandom_range(0, 1));
                end
                tick();
            end
            while (o_state == 3'd3 && off < 100) begin
                if (o_led !== 4'd0) ok = 1'b0;
                off++;
                if (noise) begin
                    btn   = 4'(1 << $urandom_range(0, 3));
                    start = 1'($urandom_range(0, 1));
                end
                tick();
            end
            check("show_on_cycles", on, ON_CYC);
            check("show_off_cycles", off, OFF_CYC);
            check("show_led", ok, 1);
        end
        btn   = 4'd0;
        start = 1'b0;
        check("wait_state", o_state, 4);
        check("wait_led", o_led, 0);
    endtask

    task automatic start_game();
        seq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Plays one round; fail_at >= 0 presses a wrong channel at that step.
    task automatic play_round(input int lvl, input int fail_at);
        int d;
        for (int i = 0; i < lvl; i++) begin
            d = $urandom_range(0, TIMEOUT_CYC - 1);
            repeat (d) begin
                start = 1'($urandom_range(0, 1));
                tick();
            end
            start = 1'b0;
            if (i == fail_at) begin
                btn = 4'(1 << ((seq[i] + 1 + $urandom_range(0, 2)) % 4));
                tick();
                btn = 4'd0;
                check("wrong_state", o_state, 6);
                check("wrong_lose", o_lose, 1);
                check("wrong_led", o_led, 0);
                check("wrong_level", o_level, lvl);
                return;
            end
            btn = 4'(1 << seq[i]);
            tick();
            btn = 4'd0;
            if (i < lvl - 1) begin
                check("echo_led", o_led, 32'(1 << seq[i]));
                check("step_state", o_state, 4);
            end else if (lvl == MAX_LEN) begin
                check("win_state", o_state, 5);
                check("win_flag", o_win, 1);
                check("win_led", o_led, 4'hF);
                check("win_level", o_level, MAX_LEN);
            end else begin
                observe_round(lvl + 1, 1'b1);
            end
        end
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_led", o_led, 0);
        check("rst_level", o_level, 0);
        check("rst_state", o_state, 0);
        check("rst_win", o_win, 0);
        check("rst_lose", o_lose, 0);
        btn = 4'b0001;
        tick();
        btn = 4'd0;
        check("idle_ignores_btn", o_state, 0);

        // First round with exact timing, then a press on the last allowed cycle
        start_game();
        observe_round(1, 1'b0);
        repeat (TIMEOUT_CYC - 1) tick();
        btn = 4'(1 << seq[0]);
        tick();
        btn = 4'd0;
        observe_round(2, 1'b1);

        // Wrong channel at step 0, LOSE is sticky, restart gives level 1
        btn = 4'(1 << ((seq[0] + 1) % 4));
        tick();
        btn = 4'd0;
        check("lose_state", o_state, 6);
        check("lose_flag", o_lose, 1);
        check("lose_led", o_led, 0);
        repeat (3) tick();
        check("lose_sticky", o_lose, 1);
        check("lose_level_kept", o_level, 2);
        start_game();
        observe_round(1, 1'b0);

        // Timeout: still waiting after 19 idle cycles, lost after 20
        repeat (TIMEOUT_CYC - 1) tick();
        check("pre_timeout_state", o_state, 4);
        tick();
        check("timeout_state", o_state, 6);
        check("timeout_lose", o_lose, 1);

        // Multi-hot press loses
        start_game();
        observe_round(1, 1'b0);
        btn = 4'b0011;
        tick();
        btn = 4'd0;
        check("multihot_state", o_state, 6);

        // Full game to WIN
        start_game();
        observe_round(1, 1'b1);
        for (int l = 1; l <= MAX_LEN; l++) play_round(l, -1);
        repeat (2) tick();
        check("win_sticky", o_win, 1);
        check("win_led_sticky", o_led, 4'hF);

        // Asynchronous reset during SHOW_ON
        start_game();
        tick();
        tick();
        check("pre_rst_show", o_state, 2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", o_led, 0);
        check("async_rst_state", o_state, 0);
        check("async_rst_level", o_level, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_state", o_state, 0);

        // Randomised games with occasional wrong presses
        for (int g = 0; g < 6; g++) begin
            int fail_lvl, fail_step;
            fail_lvl  = $urandom_range(1, MAX_LEN + 2);
            fail_step = 0;
            start_game();
            observe_round(1, 1'b1);
            for (int l = 1; l <= MAX_LEN; l++) begin
                if (l == fail_lvl) begin
                    fail_step = $urandom_range(0, l - 1);
                    play_round(l, fail_step);
                    break;
                end
                play_round(l, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
